offset_aabb: RTL and testbench

//   Translates an axis-aligned bounding box by a 3D fixed-point offset (world/instance shift).

---
 rtl/offset_aabb.sv | 56 +++++
 tb/tb_offset_aabb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offset_aabb.sv
// Translates an axis-aligned bounding box by a 3D fixed-point offset, one registered stage.
// Optional feature macro: OFFSET_AABB_SATURATE_EN (saturating adds instead of wrapping adds).
module offset_aabb #(
    parameter int FIXED_WIDTH = 32,
    parameter int FRAC_BITS   = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [3*FIXED_WIDTH-1:0] offset,
    input  logic [6*FIXED_WIDTH-1:0] aabb,
    output logic                     out_valid,
    output logic [6*FIXED_WIDTH-1:0] out_aabb
);

    localparam int W = FIXED_WIDTH;

    // The binary point never affects the adds; it only has to be a sensible format.
    if (FRAC_BITS < 0 || FRAC_BITS >= FIXED_WIDTH) begin : g_bad_frac_bits
        $error("offset_aabb: FRAC_BITS must lie in [0, FIXED_WIDTH)");
    end

    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
`ifdef OFFSET_AABB_SATURATE_EN
        // Overflow only when both operands share a sign and the sum's sign differs.
        if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
            s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    logic [6*W-1:0] next_aabb;

    // Lanes 0..2 are Min.X/Y/Z, lanes 3..5 are Max.X/Y/Z; each gets its own adder.
    for (genvar k = 0; k < 6; k++) begin : g_lane
        localparam int AXIS = k % 3;
        assign next_aabb[(6-k)*W-1 -: W] =
            lane_add(aabb[(6-k)*W-1 -: W], offset[(3-AXIS)*W-1 -: W]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_aabb  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_aabb <= next_aabb;
            end
        end
    end

endmodule

// File: tb/tb_offset_aabb.sv
// Directed-vector bench for offset_aabb: reset, translation, hold, streaming, overflow, mid-stream reset.
// Expectations follow OFFSET_AABB_SATURATE_EN when the bench is built with it defined.
module tb_offset_aabb;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic [95:0]  offset;
    logic [191:0] aabb;
    logic         out_valid;
    logic [191:0] out_aabb;

    int vectors;
    int miscompares;

    offset_aabb #(.FIXED_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .offset    (offset),
        .aabb      (aabb),
        .out_valid (out_valid),
        .out_aabb  (out_aabb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [191:0] box(input logic [31:0] mnx, input logic [31:0] mny,
                                         input logic [31:0] mnz, input logic [31:0] mxx,
                                         input logic [31:0] mxy, input logic [31:0] mxz);
        return {mnx, mny, mnz, mxx, mxy, mxz};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        in_valid = 1'b1;
        aabb     = box(32'h11111111, 32'h22222222, 32'h33333333,
                       32'h44444444, 32'h55555555, 32'h66666666);
        offset   = {32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (out_aabb !== 192'h0) begin
            miscompares++;
            $display("FAIL reset_aabb: got %h expected 0", out_aabb);
        end
        resetn   = 1'b1;
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [191:0] exp;
        exp      = box(32'h00018000, 32'h00010000, 32'h00030000,
                       32'h00048000, 32'h00040000, 32'h00060000);
        aabb     = box(32'h00010000, 32'h00020000, 32'h00030000,
                       32'h00040000, 32'h00050000, 32'h00060000);
        offset   = {32'h00008000, 32'hFFFF0000, 32'h00000000};
        in_valid = 1'b1;
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_no_comb_path: got %b expected 0", out_valid);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid: got %b expected 1", out_valid);
        end
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL basic_aabb: got %h expected %h", out_aabb, exp);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_valid_drop: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_hold();
        logic [191:0] exp;
        exp      = box(32'h00030000, 32'h00030000, 32'h00030000,
                       32'h00040000, 32'h00040000, 32'h00040000);
        aabb     = box(32'h00020000, 32'h00010000, 32'h00000000,
                       32'h00030000, 32'h00020000, 32'h00010000);
        offset   = {32'h00010000, 32'h00020000, 32'h00030000};
        in_valid = 1'b1;
        step();
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL hold_first: got %h expected %h", out_aabb, exp);
        end
        in_valid = 1'b0;
        aabb     = box(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        offset   = {32'h12345678, 32'h12345678, 32'h12345678};
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_valid: got %b expected 0", out_valid);
        end
        step();
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL hold_aabb: got %h expected %h", out_aabb, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  offs  [3];
        logic [31:0]  mnx   [3];
        logic [31:0]  mxx   [3];
        logic [191:0] exp;
        offs = '{32'h00000000, 32'h00010000, 32'h00020000};
        mnx  = '{32'h00010000, 32'h00020000, 32'h00030000};
        mxx  = '{32'h00040000, 32'h00050000, 32'h00060000};
        aabb = box(32'h00010000, 32'h00020000, 32'h00030000,
                   32'h00040000, 32'h00050000, 32'h00060000);
        for (int i = 0; i < 3; i++) begin
            offset   = {offs[i], 32'h0, 32'h0};
            in_valid = 1'b1;
            step();
            exp = box(mnx[i], 32'h00020000, 32'h00030000,
                      mxx[i], 32'h00050000, 32'h00060000);
            vectors++;
            if (out_valid !== 1'b1 || out_aabb !== exp) begin
                miscompares++;
                $display("FAIL stream_%0d: got valid=%b aabb=%h expected valid=1 aabb=%h",
                         i, out_valid, out_aabb, exp);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [191:0] exp;
`ifdef OFFSET_AABB_SATURATE_EN
        exp = box(32'h00020000, 32'h00000000, 32'h80000000,
                  32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF);
`else
        exp = box(32'h00020000, 32'h00000000, 32'h7FFFFFFF,
                  32'h80010000, 32'h00000000, 32'hFFFFFFFF);
`endif
        aabb     = box(32'h00000000, 32'h00000000, 32'h80000000,
                       32'h7FFF0000, 32'h00000000, 32'h00000000);
        offset   = {32'h00020000, 32'h00000000, 32'hFFFFFFFF};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_aabb[95:64] !== exp[95:64]) begin
            miscompares++;
            $display("FAIL overflow_max_x: got %h expected %h", out_aabb[95:64], exp[95:64]);
        end
        vectors++;
        if (out_aabb[127:96] !== exp[127:96]) begin
            miscompares++;
            $display("FAIL underflow_min_z: got %h expected %h", out_aabb[127:96], exp[127:96]);
        end
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL overflow_aabb: got %h expected %h", out_aabb, exp);
        end
    endtask

    task automatic test_zero_offset();
        logic [191:0] exp;
        exp      = box(32'hDEADBEEF, 32'h80000001, 32'h7FFFFFFE,
                       32'h00000001, 32'hCAFEF00D, 32'h12345678);
        aabb     = exp;
        offset   = 96'h0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL zero_offset: got %h expected %h", out_aabb, exp);
        end
    endtask

    task automatic test_unordered();
        logic [191:0] exp;
        exp      = box(32'h00060000, 32'hFFFF0000, 32'h00000000,
                       32'h00020000, 32'hFFFD0000, 32'hFFFF8000);
        aabb     = box(32'h00050000, 32'h00000000, 32'h00008000,
                       32'h00010000, 32'hFFFE0000, 32'h00000000);
        offset   = {32'h00010000, 32'hFFFF0000, 32'hFFFF8000};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_aabb !== exp) begin
            miscompares++;
            $display("FAIL unordered: got %h expected %h", out_aabb, exp);
        end
    endtask

    task automatic test_reset_midstream();
        logic [191:0] exp_a;
        logic [191:0] exp_c;
        exp_a    = box(32'h00020000, 32'h00020000, 32'h00020000,
                       32'h00030000, 32'h00030000, 32'h00030000);
        exp_c    = box(32'h00070000, 32'h00080000, 32'h00090000,
                       32'h000A0000, 32'h000B0000, 32'h000C0000);
        aabb     = box(32'h00010000, 32'h00010000, 32'h00010000,
                       32'h00020000, 32'h00020000, 32'h00020000);
        offset   = {32'h00010000, 32'h00010000, 32'h00010000};
        in_valid = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_aabb !== exp_a) begin
            miscompares++;
            $display("FAIL midrst_before: got valid=%b aabb=%h expected valid=1 aabb=%h",
                     out_valid, out_aabb, exp_a);
        end
        resetn = 1'b0;
        aabb   = box(32'h11110000, 32'h22220000, 32'h33330000,
                     32'h44440000, 32'h55550000, 32'h66660000);
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_aabb !== 192'h0) begin
            miscompares++;
            $display("FAIL midrst_cleared: got valid=%b aabb=%h expected valid=0 aabb=0",
                     out_valid, out_aabb);
        end
        resetn = 1'b1;
        aabb   = box(32'h00060000, 32'h00070000, 32'h00080000,
                     32'h00090000, 32'h000A0000, 32'h000B0000);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_aabb !== exp_c) begin
            miscompares++;
            $display("FAIL midrst_after: got valid=%b aabb=%h expected valid=1 aabb=%h",
                     out_valid, out_aabb, exp_c);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        offset      = '0;
        aabb        = '0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_overflow();
        test_zero_offset();
        test_unordered();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
